// File: rtl/regfile_latch_pkg.sv
// Helper functions for the latch-based register file: one-hot decode,
// lowest-index priority select and same-address write collision detect.
package regfile_latch_pkg;

  virtual class regfile_latch_fn #(
    parameter int unsigned AW = 5,
    parameter int unsigned NP = 2
  );
    localparam int unsigned NW = 1 << AW;
    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;

    static function logic [NW-1:0] decode(input logic [AW-1:0] addr);
      logic [NW-1:0] onehot;
      onehot       = '0;
      onehot[addr] = 1'b1;
      return onehot;
    endfunction

    // Index of the lowest set request bit; 0 when none is set.
    static function logic [IW-1:0] prio_idx(input logic [NP-1:0] req);
      logic [IW-1:0] idx;
      logic          found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NP; i++) begin
        if (req[i] && !found) begin
          idx   = IW'(i);
          found = 1'b1;
        end
      end
      return idx;
    endfunction

    static function logic collision(input logic [NP-1:0] we,
                                    input logic [NP*AW-1:0] addr);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < NP; i++) begin
        for (int unsigned j = i + 1; j < NP; j++) begin
          if (we[i] && we[j] && (addr[i*AW +: AW] == addr[j*AW +: AW])) begin
            hit = 1'b1;
          end
        end
      end
      return hit;
    endfunction
  endclass

endpackage

// File: rtl/cluster_clock_gating.sv
// Latch-based integrated clock gate: enable is captured while clk_i is low.
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic r_clk_en;

  always_latch begin
    if (!clk_i) r_clk_en <= en_i | test_en_i;
  end

  assign clk_o = clk_i & r_clk_en;

endmodule

// File: rtl/regfile_latch_wport.sv
// Per-write-port sample stage: registers write data and the one-hot word select.
module regfile_latch_wport
  import regfile_latch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [(1<<ADDR_WIDTH)-1:0]   o_sel,
  output logic [DATA_WIDTH-1:0]        o_data
);

  localparam int unsigned NUM_WORDS = 1 << ADDR_WIDTH;

  logic [NUM_WORDS-1:0]  r_sel;
  logic [DATA_WIDTH-1:0] r_data;

  // Select is a one-cycle pulse so it only qualifies the write sampled this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '0;
      r_data <= '0;
    end else begin
      r_sel <= i_we ? regfile_latch_fn#(ADDR_WIDTH, 1)::decode(i_addr) : '0;
      if (i_we) r_data <= i_data;
    end
  end

  assign o_sel  = r_sel;
  assign o_data = r_data;

endmodule

// File: rtl/register_file_mw_mr_latch.sv
// Multi-write/multi-read latch register file with per-word valid bits and flush.
// Optional REGFILE_LATCH_BYPASS_EN forwards same-edge write data to readers.
module register_file_mw_mr_latch
  import regfile_latch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_READ     = 2,
  parameter int unsigned N_WRITE    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         test_en_i,
  input  logic                         FlushEnable,
  input  logic [N_READ-1:0]            ReadEnable,
  input  logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
  output logic [N_READ*DATA_WIDTH-1:0] ReadData,
  output logic [N_READ-1:0]            ReadValid,
  input  logic [N_WRITE-1:0]           WriteEnable,
  input  logic [N_WRITE*ADDR_WIDTH-1:0] WriteAddr,
  input  logic [N_WRITE*DATA_WIDTH-1:0] WriteData,
  output logic                         WriteCollision
);

  localparam int unsigned NUM_WORDS = 1 << ADDR_WIDTH;

  logic [NUM_WORDS-1:0]  w_wsel_in [N_WRITE];
  logic [NUM_WORDS-1:0]  w_wsel_q  [N_WRITE];
  logic [DATA_WIDTH-1:0] w_wdata_q [N_WRITE];
  logic [NUM_WORDS-1:0]  w_word_en;
  logic [NUM_WORDS-1:0]  w_word_clk;
  logic                  w_gclk;
  logic [DATA_WIDTH-1:0] w_mem [NUM_WORDS];

  logic [NUM_WORDS-1:0]  r_valid;
  logic [ADDR_WIDTH-1:0] r_raddr [N_READ];
  logic                  r_collision;

  for (genvar p = 0; p < N_WRITE; p++) begin : g_wport
    assign w_wsel_in[p] = WriteEnable[p]
      ? regfile_latch_fn#(ADDR_WIDTH, N_WRITE)::decode(WriteAddr[p*ADDR_WIDTH +: ADDR_WIDTH])
      : '0;

    regfile_latch_wport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_wport (
      .clk    (clk),
      .rst    (rst),
      .i_we   (WriteEnable[p]),
      .i_addr (WriteAddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_data (WriteData[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_sel  (w_wsel_q[p]),
      .o_data (w_wdata_q[p])
    );
  end

  always_comb begin
    w_word_en = '0;
    for (int unsigned p = 0; p < N_WRITE; p++) w_word_en = w_word_en | w_wsel_in[p];
  end

  cluster_clock_gating u_global_gate (
    .clk_i     (clk),
    .en_i      (|WriteEnable),
    .test_en_i (test_en_i),
    .clk_o     (w_gclk)
  );

  // Word latch opens in the high phase after the write is sampled.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    logic [N_WRITE-1:0]    w_req;
    logic [DATA_WIDTH-1:0] w_word_data;
    logic [DATA_WIDTH-1:0] r_word;

    cluster_clock_gating u_word_gate (
      .clk_i     (w_gclk),
      .en_i      (w_word_en[w]),
      .test_en_i (1'b0),
      .clk_o     (w_word_clk[w])
    );

    always_comb begin
      w_req = '0;
      for (int unsigned p = 0; p < N_WRITE; p++) w_req[p] = w_wsel_q[p][w];
      w_word_data = w_wdata_q[regfile_latch_fn#(ADDR_WIDTH, N_WRITE)::prio_idx(w_req)];
    end

    always_latch begin
      if (w_word_clk[w]) r_word <= w_word_data;
    end

    assign w_mem[w] = r_word;
  end

  // Flush wins over a same-cycle write for the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_collision <= 1'b0;
    end else begin
      r_valid     <= FlushEnable ? '0 : (r_valid | w_word_en);
      r_collision <= regfile_latch_fn#(ADDR_WIDTH, N_WRITE)::collision(WriteEnable, WriteAddr);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned z = 0; z < N_READ; z++) begin
      if (rst) begin
        r_raddr[z] <= '0;
      end else if (ReadEnable[z]) begin
        r_raddr[z] <= ReadAddr[z*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    ReadData  = '0;
    ReadValid = '0;
    for (int unsigned z = 0; z < N_READ; z++) begin
      ReadValid[z]                      = r_valid[r_raddr[z]];
      ReadData[z*DATA_WIDTH +: DATA_WIDTH] = w_mem[r_raddr[z]];
    end
`ifdef REGFILE_LATCH_BYPASS_EN
    // Forward the sampled write so readers never see the transparent latch.
    for (int unsigned z = 0; z < N_READ; z++) begin
      logic [N_WRITE-1:0] byp_req;
      byp_req = '0;
      for (int unsigned p = 0; p < N_WRITE; p++) byp_req[p] = w_wsel_q[p][r_raddr[z]];
      if (|byp_req) begin
        ReadData[z*DATA_WIDTH +: DATA_WIDTH] =
          w_wdata_q[regfile_latch_fn#(ADDR_WIDTH, N_WRITE)::prio_idx(byp_req)];
      end
    end
`endif
  end

  assign WriteCollision = r_collision;

endmodule

// File: tb/tb_register_file_mw_mr_latch.sv
// Self-checking bench for register_file_mw_mr_latch using a read scoreboard
// and a behavioural storage/valid model.
module tb_register_file_mw_mr_latch;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NWR = 2;
  localparam int NWORDS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              test_en_i;
  logic              FlushEnable;
  logic [NR-1:0]     ReadEnable;
  logic [NR*AW-1:0]  ReadAddr;
  logic [NR*DW-1:0]  ReadData;
  logic [NR-1:0]     ReadValid;
  logic [NWR-1:0]    WriteEnable;
  logic [NWR*AW-1:0] WriteAddr;
  logic [NWR*DW-1:0] WriteData;
  logic              WriteCollision;

  register_file_mw_mr_latch #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .N_READ (NR), .N_WRITE (NWR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .test_en_i      (test_en_i),
    .FlushEnable    (FlushEnable),
    .ReadEnable     (ReadEnable),
    .ReadAddr       (ReadAddr),
    .ReadData       (ReadData),
    .ReadValid      (ReadValid),
    .WriteEnable    (WriteEnable),
    .WriteAddr      (WriteAddr),
    .WriteData      (WriteData),
    .WriteCollision (WriteCollision)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int addr;
    bit chk_data;
  } rd_t;

  rd_t         sb[$];
  logic [31:0] m_mem   [NWORDS];
  bit          m_val   [NWORDS];
  bit          m_known [NWORDS];
  int          errors = 0;
  int          checks = 0;

  task automatic wr(input int p, input int a, input logic [31:0] d);
    WriteEnable[p]        = 1'b1;
    WriteAddr[p*AW +: AW] = a[AW-1:0];
    WriteData[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_t e;
    ReadEnable[p]        = 1'b1;
    ReadAddr[p*AW +: AW] = a[AW-1:0];
    e.port = p; e.addr = a; e.chk_data = 1'b1;
    sb.push_back(e);
  endtask

  // Pops every read issued last cycle and compares it against the model.
  task automatic drain();
    rd_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ReadValid[e.port] !== m_val[e.addr]) begin
        errors++;
        $display("FAIL read_valid port %0d addr %0d: got %b expected %b",
                 e.port, e.addr, ReadValid[e.port], m_val[e.addr]);
      end
      if (e.chk_data && m_known[e.addr]) begin
        checks++;
        if (ReadData[e.port*DW +: DW] !== m_mem[e.addr]) begin
          errors++;
          $display("FAIL read_data port %0d addr %0d: got %h expected %h",
                   e.port, e.addr, ReadData[e.port*DW +: DW], m_mem[e.addr]);
        end
      end
    end
  endtask

  // Updates the model with this cycle's stimulus, advances one edge, then checks.
  task automatic tick();
    bit exp_coll;
    exp_coll = 1'b0;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (WriteEnable[p] && WriteEnable[q] &&
            WriteAddr[p*AW +: AW] == WriteAddr[q*AW +: AW]) exp_coll = 1'b1;
`ifndef REGFILE_LATCH_BYPASS_EN
    foreach (sb[i])
      for (int p = 0; p < NWR; p++)
        if (WriteEnable[p] && int'(WriteAddr[p*AW +: AW]) == sb[i].addr) sb[i].chk_data = 1'b0;
`endif
    if (rst) begin
      exp_coll = 1'b0;
      for (int a = 0; a < NWORDS; a++) m_val[a] = 1'b0;
    end else begin
      for (int p = NWR - 1; p >= 0; p--) begin
        if (WriteEnable[p]) begin
          m_mem[WriteAddr[p*AW +: AW]]   = WriteData[p*DW +: DW];
          m_val[WriteAddr[p*AW +: AW]]   = 1'b1;
          m_known[WriteAddr[p*AW +: AW]] = 1'b1;
        end
      end
      if (FlushEnable) for (int a = 0; a < NWORDS; a++) m_val[a] = 1'b0;
    end
    @(posedge clk);
    #1;
    ReadEnable  = '0;
    WriteEnable = '0;
    FlushEnable = 1'b0;
    checks++;
    if (WriteCollision !== exp_coll) begin
      errors++;
      $display("FAIL write_collision: got %b expected %b", WriteCollision, exp_coll);
    end
    drain();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (ReadValid !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 00", ReadValid);
    end
    rd(0, 3);
    tick();
  endtask

  task automatic test_write_read();
    wr(1, 5, 32'hDEADBEEF);
    tick();
    rd(0, 5);
    tick();
  endtask

  task automatic test_collision();
    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    tick();
    tick();
    rd(0, 7);
    rd(1, 7);
    tick();
  endtask

  task automatic test_parallel();
    wr(0, 2, 32'hA5A50002);
    wr(1, 9, 32'h5A5A0009);
    tick();
    rd(0, 2);
    rd(1, 9);
    tick();
  endtask

  task automatic test_flush();
    for (int a = 0; a < NWORDS; a += 2) begin
      wr(0, a, $urandom);
      wr(1, a + 1, $urandom);
      tick();
    end
    rd(0, 4);
    rd(1, 10);
    tick();
    FlushEnable = 1'b1;
    wr(0, 4, 32'h4444AAAA);
    tick();
    checks++;
    if (ReadValid !== 2'b00) begin
      errors++;
      $display("FAIL flush_held_valid: got %b expected 00", ReadValid);
    end
    tick();
    checks++;
    if (ReadData[0 +: DW] !== 32'h4444AAAA) begin
      errors++;
      $display("FAIL flush_write_data: got %h expected %h", ReadData[0 +: DW], 32'h4444AAAA);
    end
    for (int a = 0; a < NWORDS; a += 2) begin
      rd(0, a);
      rd(1, a + 1);
      tick();
    end
  endtask

  task automatic test_bypass();
    wr(0, 6, 32'hCAFEF00D);
    rd(0, 6);
    tick();
    tick();
    checks++;
    if (ReadData[0 +: DW] !== 32'hCAFEF00D || ReadValid[0] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_rw_n2: got %h/%b expected %h/1",
               ReadData[0 +: DW], ReadValid[0], 32'hCAFEF00D);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1) wr(p, int'($urandom_range(0, 7)), $urandom);
      for (int z = 0; z < NR; z++)
        if ($urandom_range(0, 2) != 0) rd(z, int'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) FlushEnable = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst         = 1'b1;
    test_en_i   = 1'b0;
    FlushEnable = 1'b0;
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = '0;
    WriteAddr   = '0;
    WriteData   = '0;
    for (int a = 0; a < NWORDS; a++) begin
      m_mem[a] = '0; m_val[a] = 1'b0; m_known[a] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_collision();
    test_parallel();
    test_flush();
    test_bypass();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
